// File: rtl/temporal_buffer_ctrl.sv
// rtl/temporal_buffer_ctrl.sv - sequencing controller for the temporal buffer datapath
module temporal_buffer_ctrl #(
    parameter int NSAT                  = 3,
    parameter int LITERAL_ADDRESS_WIDTH = 11,
    parameter int NSAT_BITS             = 2,
    localparam int LW                   = LITERAL_ADDRESS_WIDTH + 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start_i,
    input  logic                   entry_valid_i,
    output logic                   entry_ready_o,
    input  logic [LW-1:0]          entry_literal_i,
    input  logic [(NSAT-1)*LW-1:0] entry_clause_lits_i,
    input  logic                   entry_broken_i,
    input  logic                   sel_valid_i,
    output logic                   sel_ready_o,
    input  logic [NSAT_BITS-1:0]   sel_index_i,
    output logic [NSAT_BITS-1:0]   tb_write_index_o,
    output logic [LW-1:0]          tb_flipped_literal_o,
    output logic [(NSAT-1)*LW-1:0] tb_clause_lits_o,
    output logic [NSAT_BITS-1:0]   tb_read_index_o,
    output logic [NSAT-1:0]        row_valid_o,
    output logic [NSAT-1:0]        row_broken_o,
    output logic                   clause_valid_o,
    input  logic                   clause_ready_i,
    output logic                   done_o,
    output logic                   err_o,
    output logic                   busy_o
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FILL   = 3'd1,
        S_SELECT = 3'd2,
        S_READ   = 3'd3,
        S_OUT    = 3'd4
    } state_t;

    localparam logic [NSAT_BITS-1:0] LAST_ROW = NSAT_BITS'(NSAT - 1);
    localparam logic [NSAT_BITS:0]   NSAT_EXT = (NSAT_BITS + 1)'(NSAT);

    state_t                   state_q, state_d;
    logic [NSAT_BITS-1:0]     cnt_q, cnt_d;
    logic [NSAT_BITS-1:0]     wr_idx_q, wr_idx_d;
    logic [NSAT_BITS-1:0]     rd_idx_q, rd_idx_d;
    logic [LW-1:0]            flip_q, flip_d;
    logic [(NSAT-1)*LW-1:0]   lits_q, lits_d;
    logic [NSAT-1:0]          row_valid_q, row_valid_d;
    logic [NSAT-1:0]          row_broken_q, row_broken_d;
    logic                     done_q, done_d;
    logic                     err_q, err_d;

    // Row flags padded to the full index range so an out-of-range selection reads as "not written"
    logic [2**NSAT_BITS-1:0]  valid_pad;
    logic [2**NSAT_BITS-1:0]  broken_pad;
    logic                     sel_legal;

    // Next-state, datapath register updates and handshake readies
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        wr_idx_d      = wr_idx_q;
        rd_idx_d      = rd_idx_q;
        flip_d        = flip_q;
        lits_d        = lits_q;
        row_valid_d   = row_valid_q;
        row_broken_d  = row_broken_q;
        done_d        = 1'b0;
        err_d         = 1'b0;
        entry_ready_o = 1'b0;
        sel_ready_o   = 1'b0;

        valid_pad                = '0;
        valid_pad[NSAT-1:0]      = row_valid_q;
        broken_pad               = '0;
        broken_pad[NSAT-1:0]     = row_broken_q;
        sel_legal = ({1'b0, sel_index_i} < NSAT_EXT) && valid_pad[sel_index_i];

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    row_valid_d  = '0;
                    row_broken_d = '0;
                    cnt_d        = '0;
                    state_d      = S_FILL;
                end
            end
            S_FILL: begin
                entry_ready_o = 1'b1;
                if (entry_valid_i) begin
                    wr_idx_d            = cnt_q;
                    flip_d              = entry_literal_i;
                    lits_d              = entry_clause_lits_i;
                    row_valid_d[cnt_q]  = 1'b1;
                    row_broken_d[cnt_q] = entry_broken_i;
                    if (cnt_q == LAST_ROW) begin
                        state_d = S_SELECT;
                    end else begin
                        cnt_d = cnt_q + NSAT_BITS'(1);
                    end
                end
            end
            S_SELECT: begin
                sel_ready_o = 1'b1;
                if (sel_valid_i) begin
                    if (!sel_legal) begin
                        err_d   = 1'b1;
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        rd_idx_d = sel_index_i;
                        if (broken_pad[sel_index_i]) begin
                            state_d = S_READ;
                        end else begin
                            done_d  = 1'b1;
                            state_d = S_IDLE;
                        end
                    end
                end
            end
            S_READ: begin
                // Buffer registers clause_o at the end of this cycle
                state_d = S_OUT;
            end
            S_OUT: begin
                if (clause_ready_i) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any evaluation in progress
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            wr_idx_q     <= '0;
            rd_idx_q     <= '0;
            flip_q       <= '0;
            lits_q       <= '0;
            row_valid_q  <= '0;
            row_broken_q <= '0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            wr_idx_q     <= wr_idx_d;
            rd_idx_q     <= rd_idx_d;
            flip_q       <= flip_d;
            lits_q       <= lits_d;
            row_valid_q  <= row_valid_d;
            row_broken_q <= row_broken_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign tb_write_index_o     = wr_idx_q;
    assign tb_flipped_literal_o = flip_q;
    assign tb_clause_lits_o     = lits_q;
    assign tb_read_index_o      = rd_idx_q;
    assign row_valid_o          = row_valid_q;
    assign row_broken_o         = row_broken_q;
    assign clause_valid_o       = (state_q == S_OUT);
    assign done_o               = done_q;
    assign err_o                = err_q;
    assign busy_o               = (state_q != S_IDLE);

endmodule
